// File: rtl/hdmi_timing_pkg.sv
// rtl/hdmi_timing_pkg.sv - 720p60 raster constants, counter widths and NES window geometry
package hdmi_timing_pkg;

    localparam int X_W = 12;
    localparam int Y_W = 11;
    localparam int NES_W = 8;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;
    localparam int H_TOTAL_720P  = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
    localparam int V_TOTAL_720P  = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

    localparam int NES_XOFF  = 256;
    localparam int NES_WIDTH = 768;
    localparam int NES_SCALE = 3;

endpackage

// File: rtl/hdmi_video_timing_if.sv
// rtl/hdmi_video_timing_if.sv - raster/look-ahead output bundle from the timing generator
interface hdmi_video_timing_if;
    import hdmi_timing_pkg::*;

    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic             de;
    logic             hsync;
    logic             vsync;
    logic             frame_start;
    logic             line_start;
    logic             req_valid;
    logic [X_W-1:0]   req_x;
    logic [Y_W-1:0]   req_y;
    logic             nes_active;
    logic [NES_W-1:0] nes_x;
    logic [NES_W-1:0] nes_y;

    modport master (
        output x, y, de, hsync, vsync, frame_start, line_start,
        output req_valid, req_x, req_y, nes_active, nes_x, nes_y
    );

    modport slave (
        input x, y, de, hsync, vsync, frame_start, line_start,
        input req_valid, req_x, req_y, nes_active, nes_x, nes_y
    );

endinterface

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - x/y raster wrap counter; outputs 0 in reset, START position on first run cycle
module raster_counter
    import hdmi_timing_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_720P,
    parameter int V_TOTAL = V_TOTAL_720P,
    parameter int START_X = 0,
    parameter int START_Y = 0
) (
    input  logic           clk,
    input  logic           rst,
    output logic [X_W-1:0] x_d,
    output logic [Y_W-1:0] y_d,
    output logic [X_W-1:0] x_q,
    output logic [Y_W-1:0] y_q
);

    localparam logic [X_W-1:0] X_LAST  = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0] X_START = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
    localparam logic [X_W-1:0] X_ONE   = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE   = Y_W'(1);

    logic run_q;
    logic run_d;

    // run_q separates the first post-reset cycle (load START) from normal advancing.
    always_comb begin
        run_d = !rst;
        x_d   = X_START;
        y_d   = Y_START;
        if (rst) begin
            x_d = '0;
            y_d = '0;
        end else if (run_q) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + Y_ONE;
            end else begin
                x_d = x_q + X_ONE;
                y_d = y_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        run_q <= run_d;
        x_q   <= x_d;
        y_q   <= y_d;
    end

endmodule

// File: rtl/hdmi_video_timing.sv
// rtl/hdmi_video_timing.sv - raster timing generator with look-ahead request stream
// Optional NES 3x window outputs enabled by HDMI_TIMING_NES_WINDOW_EN.
module hdmi_video_timing
    import hdmi_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_720P,
    parameter int   H_FP     = H_FP_720P,
    parameter int   H_SYNC   = H_SYNC_720P,
    parameter int   H_BP     = H_BP_720P,
    parameter int   V_ACTIVE = V_ACTIVE_720P,
    parameter int   V_FP     = V_FP_720P,
    parameter int   V_SYNC   = V_SYNC_720P,
    parameter int   V_BP     = V_BP_720P,
    parameter logic H_POL    = 1'b1,
    parameter logic V_POL    = 1'b1,
    parameter int   PREFETCH = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                pll_lock,
    hdmi_video_timing_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] HA_X  = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_LO = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_HI = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] VA_Y  = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_LO = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_HI = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic lock_meta_q, lock_meta_d;
    logic lock_s_q, lock_s_d;
    logic rst_i;

    always_comb begin
        lock_meta_d = pll_lock;
        lock_s_d    = lock_meta_q;
    end

    // Plain two-flop chain: pll_lock is asynchronous and must not be gated by resetn.
    always_ff @(posedge clk) begin
        lock_meta_q <= lock_meta_d;
        lock_s_q    <= lock_s_d;
    end

    assign rst_i = !resetn || !lock_s_q;

    logic [X_W-1:0] disp_x_d, disp_x_q, req_x_d, req_x_q;
    logic [Y_W-1:0] disp_y_d, disp_y_q, req_y_d, req_y_q;

    raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .START_X (0),
        .START_Y (0)
    ) u_disp (
        .clk (clk),
        .rst (rst_i),
        .x_d (disp_x_d),
        .y_d (disp_y_d),
        .x_q (disp_x_q),
        .y_q (disp_y_q)
    );

    raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .START_X (PREFETCH),
        .START_Y (0)
    ) u_req (
        .clk (clk),
        .rst (rst_i),
        .x_d (req_x_d),
        .y_d (req_y_d),
        .x_q (req_x_q),
        .y_q (req_y_q)
    );

    logic de_q, de_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic frame_start_q, frame_start_d;
    logic line_start_q, line_start_d;
    logic req_valid_q, req_valid_d;

    // Decodes use the counters' next position so the registered flags line up with x/y.
    always_comb begin
        de_d          = 1'b0;
        hsync_d       = ~H_POL;
        vsync_d       = ~V_POL;
        frame_start_d = 1'b0;
        line_start_d  = 1'b0;
        req_valid_d   = 1'b0;
        if (!rst_i) begin
            de_d          = (disp_x_d < HA_X) && (disp_y_d < VA_Y);
            hsync_d       = (disp_x_d >= HS_LO && disp_x_d < HS_HI) ? H_POL : ~H_POL;
            vsync_d       = (disp_y_d >= VS_LO && disp_y_d < VS_HI) ? V_POL : ~V_POL;
            line_start_d  = (disp_x_d == '0);
            frame_start_d = (disp_x_d == '0) && (disp_y_d == '0);
            req_valid_d   = (req_x_d < HA_X) && (req_y_d < VA_Y);
        end
    end

    always_ff @(posedge clk) begin
        de_q          <= de_d;
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        frame_start_q <= frame_start_d;
        line_start_q  <= line_start_d;
        req_valid_q   <= req_valid_d;
    end

    assign vid.x           = disp_x_q;
    assign vid.y           = disp_y_q;
    assign vid.de          = de_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.frame_start = frame_start_q;
    assign vid.line_start  = line_start_q;
    assign vid.req_valid   = req_valid_q;
    assign vid.req_x       = req_x_q;
    assign vid.req_y       = req_y_q;

`ifdef HDMI_TIMING_NES_WINDOW_EN
    localparam logic [X_W-1:0]   NES_X_LO = X_W'(NES_XOFF);
    localparam logic [X_W-1:0]   NES_X_HI = X_W'(NES_XOFF + NES_WIDTH);
    localparam logic [1:0]       SUB_LAST = 2'(NES_SCALE - 1);
    localparam logic [NES_W-1:0] NES_ONE  = NES_W'(1);

    logic [1:0]       xsub_q, xsub_d, ysub_q, ysub_d;
    logic [NES_W-1:0] xcnt_q, xcnt_d, ycnt_q, ycnt_d;
    logic [NES_W-1:0] nes_x_q, nes_x_d, nes_y_q, nes_y_d;
    logic             nes_active_q, nes_active_d;

    // Mod-3 sub-counters replace the divide: x restarts at the window edge, y at frame start.
    always_comb begin
        xsub_d = xsub_q;
        xcnt_d = xcnt_q;
        ysub_d = ysub_q;
        ycnt_d = ycnt_q;
        if (rst_i) begin
            xsub_d = '0;
            xcnt_d = '0;
            ysub_d = '0;
            ycnt_d = '0;
        end else begin
            if (disp_x_d == NES_X_LO) begin
                xsub_d = '0;
                xcnt_d = '0;
            end else if (xsub_q == SUB_LAST) begin
                xsub_d = '0;
                xcnt_d = xcnt_q + NES_ONE;
            end else begin
                xsub_d = xsub_q + 2'd1;
            end
            if (disp_x_d == '0) begin
                if (disp_y_d == '0) begin
                    ysub_d = '0;
                    ycnt_d = '0;
                end else if (ysub_q == SUB_LAST) begin
                    ysub_d = '0;
                    ycnt_d = ycnt_q + NES_ONE;
                end else begin
                    ysub_d = ysub_q + 2'd1;
                end
            end
        end
        nes_active_d = de_d && (disp_x_d >= NES_X_LO) && (disp_x_d < NES_X_HI);
        nes_x_d      = nes_active_d ? xcnt_d : '0;
        nes_y_d      = nes_active_d ? ycnt_d : '0;
    end

    always_ff @(posedge clk) begin
        xsub_q       <= xsub_d;
        xcnt_q       <= xcnt_d;
        ysub_q       <= ysub_d;
        ycnt_q       <= ycnt_d;
        nes_active_q <= nes_active_d;
        nes_x_q      <= nes_x_d;
        nes_y_q      <= nes_y_d;
    end

    assign vid.nes_active = nes_active_q;
    assign vid.nes_x      = nes_x_q;
    assign vid.nes_y      = nes_y_q;
`else
    assign vid.nes_active = 1'b0;
    assign vid.nes_x      = '0;
    assign vid.nes_y      = '0;
`endif

endmodule

// File: doc/hdmi_video_timing.md
Name: hdmi_video_timing

Overview:
- Raster timing generator clocked by the HDMI pixel clock from the HDMI PLL (74.25 MHz for 720p60).
- Produces pixel coordinates, `de`, `hsync` and `vsync` for the TMDS encoder.
- Also produces a look-ahead request stream, so the framebuffer/line-buffer read path can fetch pixels PREFETCH cycles early.
- Holds itself in reset until the PLL lock is synchronised.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, hsync width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch
- V_SYNC, 5, vsync width in lines
- V_BP, 20, vertical back porch
- H_POL, 1, hsync active level
- V_POL, 1, vsync active level
- PREFETCH, 4, request lead in pixels, range 1..H_FP

Ports:
- clk  in  1  pixel clock (PLL output)
- resetn  in  1  synchronous active-low reset
- pll_lock  in  1  PLL lock, asynchronous to clk
- x  out  12  current horizontal position, 0..H_TOTAL-1
- y  out  11  current line, 0..V_TOTAL-1
- de  out  1  active video
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- frame_start  out  1  one-cycle pulse at pixel (0,0)
- line_start  out  1  one-cycle pulse at x==0 of every line
- req_valid  out  1  req_x/req_y lie inside the active area
- req_x  out  12  position PREFETCH pixels ahead of x
- req_y  out  11  line of that look-ahead position
- nes_active  out  1  inside the NES window (optional)
- nes_x  out  8  NES source column (optional)
- nes_y  out  8  NES source line (optional)

Behaviour:
- Frame geometry: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750).
- Line order within each line: active, front porch, sync, back porch. Same order for lines within a frame.
- Lock synchroniser: `pll_lock` passes through a 2-flop synchroniser to give `lock_s`. Internal reset `rst_i = !resetn | !lock_s`.
- While `rst_i` is asserted:
  - x = 0 and y = 0.
  - de, frame_start, line_start, req_valid and nes_active = 0.
  - req_x = 0 and req_y = 0.
  - hsync = !H_POL and vsync = !V_POL.
- First edge after `rst_i` deasserts: outputs describe pixel (0,0), with de=1, frame_start=1, line_start=1, req_x=PREFETCH, req_y=0, req_valid=1.
- Each later edge advances one pixel:
  - x wraps at H_TOTAL-1 → 0 and y increments.
  - y wraps at V_TOTAL-1 → 0.
- Output alignment: all outputs are registered and describe the same pixel in the same cycle. No skew is allowed between x/y and de/hsync/vsync.
- de = (x < H_ACTIVE) && (y < V_ACTIVE).
- hsync = H_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; otherwise !H_POL.
- vsync = V_POL for whole lines with V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC. It changes at x==0.
- Look-ahead stream:
  - Implemented as a second counter pair running exactly PREFETCH raster positions ahead, with the same wrap rules.
  - (req_x, req_y) is the raster position PREFETCH pixels after (x, y), including line and frame wrap.
  - req_valid is the de decode of that position.
- Boundary checks:
  - At x = H_TOTAL-PREFETCH, y = V_TOTAL-1: req = (0,0) with req_valid=1.
  - At x = H_ACTIVE-PREFETCH: req_valid drops.
- Mid-frame faults: resetn low or pll_lock low mid-frame takes effect on the next edge (plus 2 cycles of synchroniser latency for pll_lock). The frame restarts at (0,0) after release. No partial sync pulse may be stretched.
- Simultaneous events: resetn and lock loss together behave as a single reset.

Optional Feature:
- Macro: HDMI_TIMING_NES_WINDOW_EN.
- Defined:
  - NES window is 768x720 (3x scale of 256x240), horizontally centred: XOFF = (H_ACTIVE-768)/2 = 256.
  - nes_active = de && XOFF <= x < XOFF+768.
  - nes_x = (x-XOFF)/3 and nes_y = y/3, produced by mod-3 sub-counters. No divider is allowed.
  - Aligned with x/y; held at 0 outside the window and in reset.
- Undefined: nes_active, nes_x and nes_y are tied to 0; no sub-counters.

Decomposition:
- Package `hdmi_timing_pkg` holds:
  - 720p constants (H/V active, porches, sync widths, totals).
  - Counter widths (12/11).
  - NES window constants (XOFF=256, width 768, scale 3).
- Sub-module `raster_counter`: x/y wrap counter, parameterised by totals and a reset start position. It is instantiated twice (display and look-ahead).

Test Plan:
- resetn=0 for 10 cycles, then 1 with pll_lock=1 → first cycle: x=0, y=0, de=1, frame_start=1, req_x=4, req_valid=1. hsync and vsync are 0 throughout reset.
- Run one full frame → exactly 1650*750 = 1,237,500 cycles between frame_start pulses:
  - 921,600 de cycles.
  - hsync high for x = 1390..1429 on every line.
  - vsync high for y = 725..729.
- Line wrap → x=1649 to x=0, y increments, line_start=1. At x=1276, req_valid falls; at x=1646, y=749, req=(0,0) with req_valid=1.
- Drop pll_lock mid-frame at (600,300) → outputs reach reset values 3 edges later. Re-assert → pixel (0,0) 3 edges after rise.
- With HDMI_TIMING_NES_WINDOW_EN, y=5 → x=256 gives nes_x=0, nes_y=1, nes_active=1; x=1023 gives nes_x=255; x=1024 gives nes_active=0. Without the macro, all three outputs stay 0.
